// File: rtl/nh_lcd_pixel_streamer.sv
// Streams 24-bit pixels to a parallel LCD bus as timed write beats, prefixed by a
// memory-write command and optionally synchronised to the panel tearing-effect line.
module nh_lcd_pixel_streamer #(
  parameter int unsigned BUS_WIDTH     = 8,
  parameter int unsigned WR_CYCLES     = 2,
  parameter logic [7:0]  MEM_WRITE_CMD = 8'h2C
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [31:0]          i_num_pixels,
  input  logic                 i_enable_tearing,
  input  logic                 i_mode,
  input  logic                 i_tearing_effect,
  input  logic                 i_pixel_valid,
  input  logic [23:0]          i_pixel_data,
  output logic                 o_pixel_ack,
  output logic                 o_cmd_mode,
  output logic [BUS_WIDTH-1:0] o_data_out,
  output logic                 o_write,
  output logic                 o_read,
  output logic                 o_data_out_en,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [31:0]          o_pixel_cnt,
  output logic [15:0]          o_underrun
);

  localparam logic [BUS_WIDTH-1:0] CMD_WORD = BUS_WIDTH'(MEM_WRITE_CMD);
  localparam logic [3:0]           CNT_LAST = 4'(WR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_TE, CMD, FETCH, BEAT, WAIT_TE_LOW} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           beat_cnt_reg, beat_cnt_next;
  logic [1:0]           beat_idx_reg, beat_idx_next;
  logic [23:0]          pixel_reg, pixel_next;
  logic                 mode_reg, mode_next;
  logic [31:0]          num_pixels_reg, num_pixels_next;
  logic                 tearing_reg, tearing_next;
  logic                 cmd_mode_reg, cmd_mode_next;
  logic [BUS_WIDTH-1:0] data_out_reg, data_out_next;
  logic                 write_reg, write_next;
  logic                 frame_done_reg, frame_done_next;
  logic [31:0]          pixel_cnt_reg, pixel_cnt_next;
  logic [15:0]          underrun_reg, underrun_next;

  logic       pixel_ack;
  logic       beat_last;
  logic       start_cmd;
  logic       want_pixel;
  logic       finish;
  logic [1:0] last_idx;

  // Bus word for beat idx of a pixel; the 8-bit bus uses the low byte only.
  function automatic logic [BUS_WIDTH-1:0] beat_word(input logic [23:0] px,
                                                     input logic        rgb565,
                                                     input logic [1:0]  idx);
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] w;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    w = 16'h0000;
    if (BUS_WIDTH == 16) begin
      if (rgb565)           w = {r[7:3], g[7:2], b[7:3]};
      else if (idx == 2'd0) w = {r, g};
      else                  w = {b, 8'h00};
    end else begin
      if (rgb565)           w = (idx == 2'd0) ? {8'h00, r[7:3], g[7:5]} : {8'h00, g[4:2], b[7:3]};
      else if (idx == 2'd0) w = {8'h00, r};
      else if (idx == 2'd1) w = {8'h00, g};
      else                  w = {8'h00, b};
    end
    return BUS_WIDTH'(w);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= 4'd0;
      beat_idx_reg   <= 2'd0;
      pixel_reg      <= 24'd0;
      mode_reg       <= 1'b0;
      num_pixels_reg <= 32'd0;
      tearing_reg    <= 1'b0;
      cmd_mode_reg   <= 1'b1;
      data_out_reg   <= CMD_WORD;
      write_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      pixel_cnt_reg  <= 32'd0;
      underrun_reg   <= 16'd0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      beat_idx_reg   <= beat_idx_next;
      pixel_reg      <= pixel_next;
      mode_reg       <= mode_next;
      num_pixels_reg <= num_pixels_next;
      tearing_reg    <= tearing_next;
      cmd_mode_reg   <= cmd_mode_next;
      data_out_reg   <= data_out_next;
      write_reg      <= write_next;
      frame_done_reg <= frame_done_next;
      pixel_cnt_reg  <= pixel_cnt_next;
      underrun_reg   <= underrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_cnt_next   = beat_cnt_reg;
    beat_idx_next   = beat_idx_reg;
    pixel_next      = pixel_reg;
    mode_next       = mode_reg;
    num_pixels_next = num_pixels_reg;
    tearing_next    = tearing_reg;
    cmd_mode_next   = cmd_mode_reg;
    data_out_next   = data_out_reg;
    write_next      = 1'b0;
    frame_done_next = 1'b0;
    pixel_cnt_next  = pixel_cnt_reg;
    underrun_next   = underrun_reg;
    pixel_ack       = 1'b0;
    start_cmd       = 1'b0;
    want_pixel      = 1'b0;
    finish          = 1'b0;
    beat_last       = (beat_cnt_reg == CNT_LAST);
    if (BUS_WIDTH == 16) last_idx = mode_reg ? 2'd0 : 2'd1;
    else                 last_idx = mode_reg ? 2'd1 : 2'd2;

    case (state_reg)
      IDLE: begin
        if (i_enable) begin
          mode_next       = i_mode;
          num_pixels_next = i_num_pixels;
          tearing_next    = i_enable_tearing;
          pixel_cnt_next  = 32'd0;
          underrun_next   = 16'd0;
          if (i_enable_tearing) state_next = WAIT_TE;
          else                  start_cmd  = 1'b1;
        end
      end
      WAIT_TE: begin
        if (!i_enable)             state_next = IDLE;
        else if (i_tearing_effect) start_cmd  = 1'b1;
      end
      CMD: begin
        if (!beat_last) begin
          beat_cnt_next = beat_cnt_reg + 4'd1;
        end else begin
          cmd_mode_next = 1'b1;
          if (!i_enable)                   state_next = IDLE;
          else if (num_pixels_reg == 32'd0) finish    = 1'b1;
          else                             want_pixel = 1'b1;
        end
      end
      FETCH: begin
        if (!i_enable) begin
          state_next     = IDLE;
          pixel_cnt_next = 32'd0;
        end else begin
          want_pixel = 1'b1;
        end
      end
      BEAT: begin
        if (!beat_last) begin
          beat_cnt_next = beat_cnt_reg + 4'd1;
        end else if (beat_idx_reg != last_idx) begin
          beat_idx_next = beat_idx_reg + 2'd1;
          beat_cnt_next = 4'd0;
          data_out_next = beat_word(pixel_reg, mode_reg, beat_idx_reg + 2'd1);
          write_next    = 1'b1;
        end else begin
          pixel_cnt_next = pixel_cnt_reg + 32'd1;
          // A dropped enable only takes effect once the pixel's beats are out.
          if (!i_enable) begin
            state_next     = IDLE;
            pixel_cnt_next = 32'd0;
          end else if (({1'b0, pixel_cnt_reg} + 33'd1) >= {1'b0, num_pixels_reg}) begin
            finish = 1'b1;
          end else begin
            want_pixel = 1'b1;
          end
        end
      end
      WAIT_TE_LOW: begin
        if (!i_tearing_effect) begin
          state_next      = IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (start_cmd) begin
      state_next    = CMD;
      beat_cnt_next = 4'd0;
      cmd_mode_next = 1'b0;
      data_out_next = CMD_WORD;
      write_next    = 1'b1;
    end

    if (finish) begin
      if (tearing_reg) begin
        state_next = WAIT_TE_LOW;
      end else begin
        state_next      = IDLE;
        frame_done_next = 1'b1;
      end
    end

    // Fetching straight out of the previous beat keeps back-to-back beats WR_CYCLES apart.
    if (want_pixel) begin
      if (i_pixel_valid) begin
        pixel_ack     = 1'b1;
        pixel_next    = i_pixel_data;
        state_next    = BEAT;
        beat_idx_next = 2'd0;
        beat_cnt_next = 4'd0;
        data_out_next = beat_word(i_pixel_data, mode_reg, 2'd0);
        write_next    = 1'b1;
      end else begin
        state_next = FETCH;
        if (pixel_cnt_next != 32'd0 && underrun_reg != 16'hFFFF)
          underrun_next = underrun_reg + 16'd1;
      end
    end
  end

  assign o_pixel_ack   = pixel_ack;
  assign o_cmd_mode    = cmd_mode_reg;
  assign o_data_out    = data_out_reg;
  assign o_write       = write_reg;
  assign o_read        = 1'b0;
  assign o_data_out_en = 1'b1;
  assign o_busy        = (state_reg != IDLE);
  assign o_frame_done  = frame_done_reg;
  assign o_pixel_cnt   = pixel_cnt_reg;
  assign o_underrun    = underrun_reg;

endmodule

// File: doc/nh_lcd_pixel_streamer.md
NH_LCD_PIXEL_STREAMER -- requirements
Module: nh_lcd_pixel_streamer

Interface
REQ-001 Parameter BUS_WIDTH, default 8, LCD data bus width; legal values 8 or 16.
REQ-002 Parameter WR_CYCLES, default 2, clk cycles per bus beat; legal range 2..15.
REQ-003 Parameter MEM_WRITE_CMD, default 8'h2C, memory-write command byte, zero-extended to BUS_WIDTH.
REQ-004 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 clk  in  1  block clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 i_enable  in  1  frame engine enable.
REQ-008 i_num_pixels  in  32  pixels per frame.
REQ-009 i_enable_tearing  in  1  1 = frame start gated by tearing effect.
REQ-010 i_mode  in  1  0 = RGB888, 1 = RGB565.
REQ-011 i_tearing_effect  in  1  panel TE input, pre-synchronised.
REQ-012 i_pixel_valid  in  1  pixel available on i_pixel_data.
REQ-013 i_pixel_data  in  24  {R[7:0], G[7:0], B[7:0]}.
REQ-014 o_pixel_ack  out  1  one-cycle pulse, pixel consumed.
REQ-015 o_cmd_mode  out  1  0 = command beat, 1 = data beat.
REQ-016 o_data_out  out  BUS_WIDTH  bus data.
REQ-017 o_write  out  1  write strobe.
REQ-018 o_read  out  1  tied 0.
REQ-019 o_data_out_en  out  1  tied 1.
REQ-020 o_busy  out  1  high in every state except IDLE.
REQ-021 o_frame_done  out  1  one-cycle pulse at frame completion.
REQ-022 o_pixel_cnt  out  32  pixels written in current frame.
REQ-023 o_underrun  out  16  saturating count of mid-frame stall cycles.

Function
REQ-024 States: IDLE, WAIT_TE, CMD, FETCH, BEAT, WAIT_TE_LOW.
REQ-025 Bus beat: o_data_out stable for WR_CYCLES cycles; o_write high in the first cycle only.
REQ-026 IDLE: when i_enable=1, latch i_mode and i_num_pixels; go to WAIT_TE if i_enable_tearing=1, else CMD.
REQ-027 WAIT_TE: go to CMD in the cycle after i_tearing_effect is sampled high.
REQ-028 CMD: one beat, o_cmd_mode=0, o_data_out=MEM_WRITE_CMD; then FETCH, or finish if latched pixel count is 0.
REQ-029 FETCH: when i_pixel_valid=1, register i_pixel_data, pulse o_pixel_ack for that cycle, go to BEAT.
REQ-030 Beat table, BUS_WIDTH=8: RGB888 = 3 beats R, G, B; RGB565 = 2 beats {R[7:3],G[7:5]}, {G[4:2],B[7:3]}.
REQ-031 Beat table, BUS_WIDTH=16: RGB565 = 1 beat {R[7:3],G[7:2],B[7:3]}; RGB888 = 2 beats {R,G}, {B,8'h00}.
REQ-032 After the last beat of a pixel, increment o_pixel_cnt; if o_pixel_cnt+1 >= latched count, finish, else FETCH.
REQ-033 FETCH with i_pixel_valid=0 after the first pixel: stall with o_write=0, o_underrun +1 per cycle, saturating at 16'hFFFF.
REQ-034 Finish: if tearing enabled, go to WAIT_TE_LOW, then IDLE once i_tearing_effect=0; else go directly to IDLE; pulse o_frame_done on entry to IDLE.
REQ-035 i_enable falling mid-frame: complete the current pixel's beats, go to IDLE, no o_frame_done, o_pixel_cnt cleared.
REQ-036 o_pixel_cnt and o_underrun clear when a new frame leaves IDLE; both hold after completion until then.
REQ-037 i_mode, i_num_pixels and i_enable_tearing changes mid-frame are ignored until the next frame.
REQ-038 The pixel register and the beat index are never shared across pixels; no pixel is acknowledged twice.

Reset
REQ-039 rst=1 forces, asynchronously: state IDLE, o_cmd_mode=1, o_write=0, o_data_out=MEM_WRITE_CMD, o_pixel_ack=0, o_busy=0, o_frame_done=0, o_pixel_cnt=0, o_underrun=0.
REQ-040 rst asserted mid-frame aborts without o_frame_done; after release the block re-arms from IDLE.

Verification
REQ-041 BUS_WIDTH=8, WR_CYCLES=2, RGB888, tearing off, 2 pixels 0x112233, 0x445566 held valid -> bus shows 2C(cmd), 11, 22, 33, 44, 55, 66; one o_write per beat, 2 cycles apart; o_frame_done pulses once; o_pixel_cnt=2.
REQ-042 BUS_WIDTH=8, RGB565, pixel 0xFF8040 -> beats 0xFC, 0x08; o_pixel_ack pulses once.
REQ-043 BUS_WIDTH=16, RGB565, pixel 0xFFFFFF -> single beat 0xFFFF; RGB888, pixel 0x123456 -> beats 0x1234, 0x5600.
REQ-044 Tearing on, i_tearing_effect low 10 cycles then high -> no o_write before TE high; after last pixel, o_frame_done only after TE low.
REQ-045 i_pixel_valid low 5 cycles between pixels 1 and 2 -> o_underrun=5, o_write low throughout; i_num_pixels=0 -> command beat only, then o_frame_done.
REQ-046 rst pulsed during a beat -> all outputs at reset values that same cycle; next frame starts with a fresh command beat.
